// File: rtl/urv_sysmem_slv_pkg.sv
// urv_sysmem_slv_pkg: shared request/response bundles and
// default placement of the on-chip system SRAM window.
package urv_sysmem_slv_pkg;

  localparam logic [31:0] SYSMEM_BASE  = 32'h8000_0000;
  localparam int          SYSMEM_DEPTH = 4096;
  localparam int          MEM_ADDR_W   = $clog2(SYSMEM_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

endpackage

// File: rtl/urv_sysmem_slv_if.sv
// urv_sysmem_slv_if: sys_req/sys_resp channel between the
// cpu subsystem (master) and the system memory responder (slave).
interface urv_sysmem_slv_if;
  import urv_sysmem_slv_pkg::*;

  logic      sys_req_valid;
  logic      sys_req_ready;
  mem_req_t  sys_req;
  logic      sys_resp_valid;
  logic      sys_resp_ready;
  mem_resp_t sys_resp;

  modport master (
    output sys_req_valid,
    input  sys_req_ready,
    output sys_req,
    input  sys_resp_valid,
    output sys_resp_ready,
    input  sys_resp
  );

  modport slave (
    input  sys_req_valid,
    output sys_req_ready,
    input  sys_req,
    output sys_resp_valid,
    input  sys_resp_ready,
    output sys_resp
  );

endinterface

// File: rtl/urv_sysmem_resp_fifo.sv
// urv_sysmem_resp_fifo: small synchronous FIFO of mem_resp_t
// holding responses in order until the master takes them.
module urv_sysmem_resp_fifo
  import urv_sysmem_slv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  mem_resp_t     push_data,
  input  logic          pop,
  output mem_resp_t     head,
  output logic [CW-1:0] cnt
);

  mem_resp_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] cnt_d, cnt_q;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // next pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer and count registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // entry storage, not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // credit scheme upstream must never overfill or underrun
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(push && !pop && cnt_q == CW'(DEPTH)));
      assert (!(pop && cnt_q == '0));
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/urv_sysmem_slv.sv
// urv_sysmem_slv: system-bus responder backed by on-chip SRAM,
// one request per cycle, in-order responses, error on miss.
module urv_sysmem_slv
  import urv_sysmem_slv_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = SYSMEM_BASE,
  parameter int          MEM_DEPTH  = SYSMEM_DEPTH,
  parameter int          RESP_DEPTH = 4
) (
  input logic             clk,
  input logic             rstn,
  urv_sysmem_slv_if.slave sys
);

  localparam int          AW  = $clog2(MEM_DEPTH);
  localparam int          CW  = $clog2(RESP_DEPTH) + 1;
  localparam logic [31:0] WIN = 32'(MEM_DEPTH) << 2;

  logic [3:0][7:0] mem [MEM_DEPTH];

  logic          req_rdy;
  logic          fire;
  logic          hit;
  logic          rd_hit;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [CW:0]   occ;
  logic [CW-1:0] cnt;

  logic          s1_valid_d, s1_valid_q;
  logic          s1_err_d, s1_err_q;
  logic          s1_rd_d, s1_rd_q;
  logic [31:0]   mem_rdata_d, mem_rdata_q;

  mem_resp_t     s1_resp;
  mem_resp_t     head;
  logic          resp_vld;
  logic          pop;

  // credit, address decode and stage-1 inputs
  always_comb begin
    occ         = {1'b0, cnt} + (CW+1)'(s1_valid_q);
    req_rdy     = rstn && (occ < (CW+1)'(RESP_DEPTH));
    fire        = sys.sys_req_valid && req_rdy;
    off         = sys.sys_req.addr - MEM_BASE;
    hit         = off < WIN;
    idx         = off[2 +: AW];
    rd_hit      = fire && hit && !sys.sys_req.wen;
    s1_valid_d  = fire;
    s1_err_d    = fire && !hit;
    s1_rd_d     = rd_hit;
    mem_rdata_d = rd_hit ? mem[idx] : mem_rdata_q;
  end

  // stage-1 register: one response being formed
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_rd_q     <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_rd_q     <= s1_rd_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // byte-masked SRAM write at the accept cycle
  always_ff @(posedge clk) begin
    if (fire && hit && sys.sys_req.wen) begin
      for (int i = 0; i < 4; i++) begin
        if (sys.sys_req.wmask[i])
          mem[idx][i] <= sys.sys_req.wdata[8*i +: 8];
      end
    end
  end

  // response formed from stage 1
  always_comb begin
    s1_resp.rdata = s1_rd_q ? mem_rdata_q : '0;
    s1_resp.err   = s1_err_q;
  end

  urv_sysmem_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (s1_valid_q),
    .push_data (s1_resp),
    .pop       (pop),
    .head      (head),
    .cnt       (cnt)
  );

  assign resp_vld           = rstn && (cnt != '0);
  assign pop                = resp_vld && sys.sys_resp_ready;
  assign sys.sys_req_ready  = req_rdy;
  assign sys.sys_resp_valid = resp_vld;
  assign sys.sys_resp       = head;

endmodule

// File: tb/tb_urv_sysmem_slv.sv
// tb_urv_sysmem_slv: directed and scoreboarded checks of
// the system memory responder.
module tb_urv_sysmem_slv;
  import urv_sysmem_slv_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          RD    = 4;
  localparam logic [31:0] WIN   = 32'(DEPTH) << 2;

  typedef struct {
    logic [32:0] resp;
    int          cyc;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   last_wait;
  int   nacc;
  bit   lat_en = 1'b1;
  bit   stalled = 1'b0;
  mem_resp_t prev;
  exp_t exp_q[$];
  logic [31:0] mdl [8];

  always #5 clk = ~clk;

  urv_sysmem_slv_if sys ();

  urv_sysmem_slv #(
    .MEM_BASE   (BASE),
    .MEM_DEPTH  (DEPTH),
    .RESP_DEPTH (RD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .sys  (sys)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // response checker and stall-stability monitor
  always @(negedge clk) begin
    exp_t e;
    if (rstn && sys.sys_resp_valid && sys.sys_resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("resp", 64'(sys.sys_resp), 64'(e.resp));
        if (lat_en) chk("latency", 64'(cyc - e.cyc), 2);
      end
    end
    if (rstn && sys.sys_resp_valid && !sys.sys_resp_ready) begin
      if (stalled) chk("stall_hold", 64'(sys.sys_resp), 64'(prev));
      prev    = sys.sys_resp;
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic issue(logic [31:0] a, logic w, logic [31:0] d,
                       logic [3:0] m, logic [31:0] er, logic ee);
    int n = 0;
    sys.sys_req_valid = 1'b1;
    sys.sys_req       = '{a, w, d, m};
    @(negedge clk);
    while (!sys.sys_req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    last_wait = n;
    if (!sys.sys_req_ready) chk("req_timeout", 0, 1);
    else exp_q.push_back('{{er, ee}, cyc});
    @(posedge clk);
    #1;
    sys.sys_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, a, d, v;
    logic [3:0]  m;
    logic        w;
    int          i;

    sys.sys_req_valid  = 1'b0;
    sys.sys_req        = '0;
    sys.sys_resp_ready = 1'b1;

    // reset
    @(negedge clk);
    chk("rst_req_ready", sys.sys_req_ready, 0);
    chk("rst_resp_valid", sys.sys_resp_valid, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", sys.sys_req_ready, 1);
    chk("post_rst_resp_valid", sys.sys_resp_valid, 0);
    @(posedge clk);
    #1;

    // write then read back-to-back
    issue(BASE + 32'h10, 1, 32'hDEAD_BEEF, 4'hF, 0, 0);
    issue(BASE + 32'h10, 0, 0, 4'h0, 32'hDEAD_BEEF, 0);
    drain();

    // byte-lane merges
    issue(BASE + 32'h20, 1, 32'h1122_3344, 4'hF, 0, 0);
    issue(BASE + 32'h20, 1, 32'h0000_00AA, 4'b0001, 0, 0);
    issue(BASE + 32'h20, 0, 0, 4'h0, 32'h1122_33AA, 0);
    issue(BASE + 32'h20, 1, 32'h5500_0000, 4'b1000, 0, 0);
    issue(BASE + 32'h20, 0, 0, 4'h0, 32'h5522_33AA, 0);
    drain();

    // window boundaries
    issue(BASE + WIN - 4, 1, 32'hCAFE_F00D, 4'hF, 0, 0);
    issue(BASE, 1, 32'h0BAD_C0DE, 4'hF, 0, 0);
    issue(BASE + WIN, 0, 0, 4'h0, 0, 1);
    issue(BASE - 4, 0, 0, 4'h0, 0, 1);
    issue(BASE + WIN, 1, 32'hFFFF_FFFF, 4'hF, 0, 1);
    issue(BASE - 4, 1, 32'hFFFF_FFFF, 4'hF, 0, 1);
    issue(BASE + WIN - 4, 0, 0, 4'h0, 32'hCAFE_F00D, 0);
    issue(BASE, 0, 0, 4'h0, 32'h0BAD_C0DE, 0);
    issue(BASE + 32'h12, 0, 0, 4'h0, 32'hDEAD_BEEF, 0);
    drain();

    // backpressure: fill the response FIFO
    for (int k = 0; k < 4; k++)
      issue(BASE + 32'h100 + 32'(4*k), 1, 32'hA000_0000 + 32'(k), 4'hF, 0, 0);
    drain();
    lat_en = 1'b0;
    sys.sys_resp_ready = 1'b0;
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      sys.sys_req_valid = 1'b1;
      sys.sys_req = '{BASE + 32'h100 + 32'(4*(nacc%4)), 1'b0, 32'h0, 4'h0};
      @(negedge clk);
      if (sys.sys_req_ready) begin
        exp_q.push_back('{{32'hA000_0000 + 32'(nacc), 1'b0}, cyc});
        nacc++;
      end
      @(posedge clk);
      #1;
    end
    sys.sys_req_valid = 1'b0;
    chk("stall_accepts", nacc, RD);
    @(negedge clk);
    chk("stall_req_ready", sys.sys_req_ready, 0);
    chk("stall_resp_valid", sys.sys_resp_valid, 1);
    @(posedge clk);
    #1 sys.sys_resp_ready = 1'b1;
    drain();
    lat_en = 1'b1;

    // sustained random traffic against a word model
    for (int k = 0; k < 8; k++) begin
      v = $urandom;
      mdl[k] = v;
      issue(BASE + 32'h200 + 32'(4*k), 1, v, 4'hF, 0, 0);
    end
    for (int k = 0; k < 100; k++) begin
      r = $urandom;
      i = int'(r[2:0]);
      w = r[3];
      m = r[7:4];
      d = $urandom;
      if (r[10:8] == 3'd0) begin
        a = r[11] ? BASE + WIN + 32'(4*i) : BASE - 4 - 32'(4*i);
        issue(a, w, d, m, 0, 1);
      end else begin
        a = BASE + 32'h200 + 32'(4*i);
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (m[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
          issue(a, 1, d, m, 0, 0);
        end else begin
          issue(a, 0, d, m, mdl[i], 0);
        end
      end
      chk("sustain", last_wait, 0);
    end
    drain();

    // reset with responses queued
    lat_en = 1'b0;
    sys.sys_resp_ready = 1'b0;
    issue(BASE + 32'h300, 1, 32'h1234_5678, 4'hF, 0, 0);
    issue(BASE + 32'h304, 1, 32'h9ABC_DEF0, 4'hF, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_resp_valid", sys.sys_resp_valid, 1);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_ready", sys.sys_req_ready, 0);
    chk("mid_rst_resp_valid", sys.sys_resp_valid, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("after_rst_resp_valid", sys.sys_resp_valid, 0);
    chk("after_rst_req_ready", sys.sys_req_ready, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_rst_flushed", sys.sys_resp_valid, 0);
    @(posedge clk);
    #1 sys.sys_resp_ready = 1'b1;
    lat_en = 1'b1;
    issue(BASE + 32'h300, 0, 0, 4'h0, 32'h1234_5678, 0);
    issue(BASE + 32'h304, 0, 0, 4'h0, 32'h9ABC_DEF0, 0);
    issue(BASE + 32'h10, 0, 0, 4'h0, 32'hDEAD_BEEF, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
